// File: rtl/iob_ila_dump_pkg.sv
// Shared types and sizing helpers for the ILA capture dumper.
package iob_ila_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_N,
    ST_WR_IDX,
    ST_WR_SEL,
    ST_RD_DAT,
    ST_OUT,
    ST_FIN
  } state_t;

  // Number of stream words needed to carry one sample.
  function automatic int calc_words(input int signal_w, input int data_w);
    return (signal_w + data_w - 1) / data_w;
  endfunction

  function automatic int calc_sel_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/iob_ila_dump_req.sv
// Single-outstanding IOb request holder.
// Takes an issue pulse from the FSM and reports completion as a one-cycle done.
module iob_ila_dump_req #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              cke,
  input  logic              arst_n,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_wdata,
  input  logic              issue_write,
  output logic              idle,
  output logic              done,
  output logic              iob_avalid,
  output logic [ADDR_W-1:0] iob_addr,
  output logic [DATA_W-1:0] iob_wdata,
  output logic [DATA_W/8-1:0] iob_wstrb,
  input  logic              iob_ready,
  input  logic              iob_rvalid
);

  logic rd_q;
  logic wait_q;
  logic accept;

  assign idle   = !iob_avalid && !wait_q;
  assign accept = iob_avalid && iob_ready;
  // A read may see its rvalid in the very cycle it is accepted.
  assign done   = cke && ((accept && (!rd_q || iob_rvalid)) || (wait_q && iob_rvalid));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      iob_avalid <= 1'b0;
      iob_addr   <= '0;
      iob_wdata  <= '0;
      iob_wstrb  <= '0;
      rd_q       <= 1'b0;
      wait_q     <= 1'b0;
    end else if (cke) begin
      if (issue && idle) begin
        iob_avalid <= 1'b1;
        iob_addr   <= issue_addr;
        iob_wdata  <= issue_wdata;
        iob_wstrb  <= issue_write ? '1 : '0;
        rd_q       <= !issue_write;
      end else if (accept) begin
        iob_avalid <= 1'b0;
        wait_q     <= rd_q && !iob_rvalid;
      end else if (wait_q && iob_rvalid) begin
        wait_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iob_ila_dump.sv
// Drains a triggered ILA capture through its CSR responder and streams every
// sample word, sample-major and word-minor, with end-of-sample/capture flags.
module iob_ila_dump
  import iob_ila_dump_pkg::*;
#(
  parameter int DATA_W             = 32,
  parameter int ADDR_W             = 4,
  parameter int SIGNAL_W           = 64,
  parameter int BUFFER_W           = 10,
  parameter int N_SAMPLES_ADDR     = 0,
  parameter int INDEX_ADDR         = 1,
  parameter int SIGNAL_SELECT_ADDR = 2,
  parameter int SAMPLE_DATA_ADDR   = 3
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i,
  output logic [DATA_W-1:0]   m_tdata_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic                m_tuser_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // RD_N   | reading N_SAMPLES
  // WR_IDX | writing INDEX with the current sample
  // WR_SEL | writing SIGNAL_SELECT with the current word
  // RD_DAT | reading SAMPLE_DATA
  // OUT    | holding a word on the stream
  // FIN    | one-cycle done pulse

  localparam int WORDS    = calc_words(SIGNAL_W, DATA_W);
  localparam int SEL_W    = calc_sel_w(WORDS);
  localparam int TOP_BITS = SIGNAL_W - (WORDS - 1) * DATA_W;
  localparam logic [DATA_W-1:0] TOP_MASK = {DATA_W{1'b1}} >> (DATA_W - TOP_BITS);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(WORDS - 1);

  state_t state, state_nxt;
  logic [BUFFER_W-1:0] n_q, idx_q, n_rd, n_last;
  logic [SEL_W-1:0]    sel_q;
  logic                abort_q, abort_now;
  logic                req_idle, req_done, issue, req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata, word;
  logic                load_n, inc_sel, inc_idx, load_word, drop_word;

  assign abort_now = abort_q | abort_i;
  assign n_rd      = iob_rdata_i[BUFFER_W-1:0];
  assign n_last    = n_q - BUFFER_W'(1);
  assign word      = (sel_q == SEL_LAST) ? (iob_rdata_i & TOP_MASK) : iob_rdata_i;
  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_FIN);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    load_n    = 1'b0;
    inc_sel   = 1'b0;
    inc_idx   = 1'b0;
    load_word = 1'b0;
    drop_word = 1'b0;
    case (state)
      ST_IDLE: if (start_i && !abort_i) state_nxt = ST_RD_N;
      ST_RD_N: begin
        req_addr = ADDR_W'(N_SAMPLES_ADDR);
        if (req_done) begin
          if (abort_now) state_nxt = ST_IDLE;
          else begin
            load_n    = 1'b1;
            state_nxt = (n_rd == '0) ? ST_FIN : ST_WR_IDX;
          end
        end
      end
      ST_WR_IDX: begin
        req_addr  = ADDR_W'(INDEX_ADDR);
        req_write = 1'b1;
        req_wdata = DATA_W'(idx_q);
        if (req_done) state_nxt = abort_now ? ST_IDLE : ST_WR_SEL;
      end
      ST_WR_SEL: begin
        req_addr  = ADDR_W'(SIGNAL_SELECT_ADDR);
        req_write = 1'b1;
        req_wdata = DATA_W'(sel_q);
        if (req_done) state_nxt = abort_now ? ST_IDLE : ST_RD_DAT;
      end
      ST_RD_DAT: begin
        req_addr = ADDR_W'(SAMPLE_DATA_ADDR);
        if (req_done) begin
          if (abort_now) state_nxt = ST_IDLE;
          else begin
            load_word = 1'b1;
            state_nxt = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (abort_now) begin
          drop_word = 1'b1;
          state_nxt = ST_IDLE;
        end else if (m_tready_i) begin
          drop_word = 1'b1;
          if (sel_q != SEL_LAST) begin
            inc_sel   = 1'b1;
            state_nxt = ST_WR_SEL;
          end else if (idx_q != n_last) begin
            inc_idx   = 1'b1;
            state_nxt = ST_WR_IDX;
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Request states launch their access once the holder is free; an abort
    // seen before launch leaves without touching the bus.
    if ((state inside {ST_RD_N, ST_WR_IDX, ST_WR_SEL, ST_RD_DAT}) && req_idle) begin
      if (abort_now) state_nxt = ST_IDLE;
      else issue = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= ST_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      abort_q    <= 1'b0;
      m_tdata_o  <= '0;
      m_tvalid_o <= 1'b0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
    end else if (cke_i) begin
      state   <= state_nxt;
      abort_q <= (state == ST_IDLE) ? 1'b0 : (abort_q | abort_i);
      if (load_n) begin
        n_q   <= n_rd;
        idx_q <= '0;
        sel_q <= '0;
      end
      if (inc_sel) sel_q <= sel_q + SEL_W'(1);
      if (inc_idx) begin
        idx_q <= idx_q + BUFFER_W'(1);
        sel_q <= '0;
      end
      if (load_word) begin
        m_tdata_o  <= word;
        m_tvalid_o <= 1'b1;
        m_tuser_o  <= (sel_q == SEL_LAST);
        m_tlast_o  <= (sel_q == SEL_LAST) && (idx_q == n_last);
      end else if (drop_word) begin
        m_tvalid_o <= 1'b0;
        m_tuser_o  <= 1'b0;
        m_tlast_o  <= 1'b0;
      end
    end
  end

  iob_ila_dump_req #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_req (
    .clk        (clk_i),
    .cke        (cke_i),
    .arst_n     (arst_n_i),
    .issue      (issue),
    .issue_addr (req_addr),
    .issue_wdata(req_wdata),
    .issue_write(req_write),
    .idle       (req_idle),
    .done       (req_done),
    .iob_avalid (iob_avalid_o),
    .iob_addr   (iob_addr_o),
    .iob_wdata  (iob_wdata_o),
    .iob_wstrb  (iob_wstrb_o),
    .iob_ready  (iob_ready_i),
    .iob_rvalid (iob_rvalid_i)
  );

endmodule

// File: tb/tb_iob_ila_dump.sv
// Scoreboard bench for iob_ila_dump: an ILA CSR model answers the IOb side,
// a monitor pops expected stream words as they are accepted.
module tb_iob_ila_dump;

  logic        clk = 1'b0;
  logic        cke, arst_n, start, abort;
  logic        busy, done, avalid, ready, rvalid;
  logic [3:0]  addr, wstrb;
  logic [31:0] wdata, rdata, tdata;
  logic        tvalid, tready, tlast, tuser;

  logic        start40, busy40, done40, avalid40, ready40, rvalid40;
  logic [3:0]  addr40, wstrb40;
  logic [31:0] wdata40, rdata40, tdata40;
  logic        tvalid40, tready40, tlast40, tuser40;

  always #5 clk = ~clk;

  iob_ila_dump u_dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .iob_avalid_o(avalid), .iob_addr_o(addr),
    .iob_wdata_o(wdata), .iob_wstrb_o(wstrb), .iob_rvalid_i(rvalid), .iob_rdata_i(rdata),
    .iob_ready_i(ready), .m_tdata_o(tdata), .m_tvalid_o(tvalid), .m_tready_i(tready),
    .m_tlast_o(tlast), .m_tuser_o(tuser)
  );

  iob_ila_dump #(.SIGNAL_W(40)) u_dut40 (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .start_i(start40), .abort_i(1'b0),
    .busy_o(busy40), .done_o(done40), .iob_avalid_o(avalid40), .iob_addr_o(addr40),
    .iob_wdata_o(wdata40), .iob_wstrb_o(wstrb40), .iob_rvalid_i(rvalid40), .iob_rdata_i(rdata40),
    .iob_ready_i(ready40), .m_tdata_o(tdata40), .m_tvalid_o(tvalid40), .m_tready_i(tready40),
    .m_tlast_o(tlast40), .m_tuser_o(tuser40)
  );

  // 40-bit ILA: one sample, every data read returns all ones.
  assign ready40  = 1'b1;
  assign tready40 = 1'b1;
  assign rvalid40 = avalid40 && (wstrb40 == 4'h0);
  assign rdata40  = (addr40 == 4'd0) ? 32'd1 : 32'hFFFF_FFFF;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  logic [33:0] exp_q[$];
  logic [33:0] q40[$];
  logic [33:0] exp6 [6];

  // ILA model state
  logic [63:0] samples [4];
  logic [31:0] reg_idx, reg_sel, rd_val;
  logic [63:0] smp;
  int          n_cfg, ready_rand, rd_mode, tready_mode;
  bit          rd_pend, pend_before, held, dat_rd_seen;
  int          rd_wait, d, reads, rv_cyc;
  logic [39:0] h_req;

  initial begin
    ready = 1'b0; rvalid = 1'b0; rdata = '0;
    rd_pend = 0; held = 0; reads = 0; rv_cyc = 0; reg_idx = '0; reg_sel = '0;
    forever begin
      @(negedge clk);
      ready = 1'b0;
      rvalid = 1'b0;
      if (!arst_n) begin
        rd_pend = 0;
        held = 0;
        continue;
      end
      pend_before = rd_pend;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          rvalid = 1'b1; rdata = rd_val; rd_pend = 0; rv_cyc = cyc;
        end else rd_wait--;
      end
      if (avalid) begin
        check("one_outstanding", 64'(pend_before), 0);
        check("wstrb_legal", 64'((wstrb == 4'h0) || (wstrb == 4'hF)), 1);
        if (held) check("req_stable", {24'h0, addr, wdata, wstrb}, {24'h0, h_req});
        ready = (ready_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ready) begin
          held = 0;
          if (wstrb == 4'hF) begin
            if (addr == 4'd1) reg_idx = wdata;
            else if (addr == 4'd2) reg_sel = wdata;
          end else begin
            reads++;
            smp = samples[reg_idx[1:0]];
            if (addr == 4'd0) rd_val = 32'(n_cfg);
            else if (addr == 4'd3) rd_val = reg_sel[0] ? smp[63:32] : smp[31:0];
            else rd_val = '0;
            if (rd_mode == 1) d = $urandom_range(0, 3);
            else if (rd_mode == 2 && addr == 4'd3) d = 3;
            else d = 0;
            if (addr == 4'd3) dat_rd_seen = 1;
            if (d == 0) begin
              rvalid = 1'b1; rdata = rd_val; rv_cyc = cyc;
            end else begin
              rd_pend = 1; rd_wait = d - 1;
            end
          end
        end else begin
          held = 1;
          h_req = {addr, wdata, wstrb};
        end
      end
    end
  end

  int done_cnt = 0, done_cyc = 0, done40_cnt = 0;
  logic [33:0] e;

  initial begin
    tready = 1'b1;
    forever begin
      @(negedge clk);
      tready = (tready_mode == 0) ? 1'b1 : (tready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL stream_unexpected got=%0h exp=none", tdata);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {30'h0, tdata, tuser, tlast}, {30'h0, e});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done40) done40_cnt++;
      if (tvalid40) begin
        if (q40.size() == 0) begin
          checks++; failures++;
          $display("FAIL stream40_unexpected got=%0h exp=none", tdata40);
        end else check("stream40_word", {30'h0, tdata40, tuser40, tlast40}, {30'h0, q40.pop_front()});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin got = 1; break; end
    end
    check({name, "_done_seen"}, 64'(got), 1);
  endtask

  task automatic run_dump(input string name, input bit restart_mid);
    int d0;
    for (int i = 0; i < 6; i++) exp_q.push_back(exp6[i]);
    d0 = done_cnt;
    pulse_start();
    if (restart_mid) begin
      repeat (15) @(negedge clk);
      pulse_start();
    end
    wait_done(name, 1500);
    repeat (10) @(negedge clk);
    check({name, "_done_once"}, 64'(done_cnt - d0), 1);
    check({name, "_all_words"}, 64'(exp_q.size()), 0);
    check({name, "_idle"}, 64'(busy), 0);
  endtask

  int  d0, rd0, n_av, n_tv, low_cyc;
  bit  got;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp6[0] = {32'hAAAA_0001, 2'b00}; exp6[1] = {32'h1111_0000, 2'b10};
    exp6[2] = {32'hAAAA_0002, 2'b00}; exp6[3] = {32'h1111_0000, 2'b10};
    exp6[4] = {32'hAAAA_0003, 2'b00}; exp6[5] = {32'h1111_0000, 2'b11};
    for (int i = 0; i < 4; i++) samples[i] = 64'h1111_0000_AAAA_0000 + 64'(i + 1);
    cke = 1'b1; start = 1'b0; abort = 1'b0; start40 = 1'b0; arst_n = 1'b1;
    n_cfg = 3; ready_rand = 0; rd_mode = 0; tready_mode = 0; dat_rd_seen = 0;
    #1 arst_n = 1'b0;
    #2;
    check("reset_ctrl", {50'h0, busy, done, avalid, tvalid, tlast, tuser, addr, wstrb}, 0);
    check("reset_data", {wdata, tdata}, 0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;

    q40.push_back({32'hFFFF_FFFF, 2'b00});
    q40.push_back({32'h0000_00FF, 2'b11});
    @(negedge clk); start40 = 1'b1;
    @(negedge clk); start40 = 1'b0;

    run_dump("basic", 0);

    n_cfg = 0;
    rd0 = reads;
    run_dump_empty();
    n_cfg = 3;

    ready_rand = 1; rd_mode = 1; tready_mode = 1;
    run_dump("random", 0);
    ready_rand = 0; rd_mode = 0; tready_mode = 0;

    rd_mode = 2; dat_rd_seen = 0; d0 = done_cnt;
    pulse_start();
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dat_rd_seen) begin got = 1; break; end
    end
    check("abort_reach_data_read", 64'(got), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_av = 0; n_tv = 0; low_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (avalid) n_av++;
      if (tvalid) n_tv++;
      if (!busy && low_cyc < 0) low_cyc = cyc;
    end
    check("abort_no_avalid", 64'(n_av), 0);
    check("abort_no_tvalid", 64'(n_tv), 0);
    check("abort_no_done", 64'(done_cnt - d0), 0);
    check("abort_rvalid_consumed", 64'(rd_pend), 0);
    check("abort_idle_after_rvalid", 64'(low_cyc), 64'(rv_cyc + 1));
    rd_mode = 0;

    run_dump("double_start", 1);

    tready_mode = 2;
    pulse_start();
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tvalid) begin got = 1; break; end
    end
    check("rst_reach_out", 64'(got), 1);
    #2 arst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {50'h0, busy, done, avalid, tvalid, tlast, tuser, addr, wstrb}, 0);
    check("rst_mid_data", {wdata, tdata}, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    tready_mode = 0;
    run_dump("after_reset", 0);

    check("dut40_all_words", 64'(q40.size()), 0);
    check("dut40_done_once", 64'(done40_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic run_dump_empty();
    int dd;
    dd = done_cnt;
    pulse_start();
    wait_done("empty", 200);
    repeat (5) @(negedge clk);
    check("empty_one_read", 64'(reads - rd0), 1);
    check("empty_done_latency", 64'(done_cyc - rv_cyc), 1);
    check("empty_done_once", 64'(done_cnt - dd), 1);
    check("empty_idle", 64'(busy), 0);
  endtask

endmodule
